sample_stream_assembler: RTL
============================

Name: sample_stream_assembler

Overview:
Parametrised front end for the spike-detector top layer. Assembles DATA_WIDTH-bit samples from an 8-bit byte stream strobed by a level byte_valid pin, and tags each sample with a channel taken from the selector pins or an internal round-robin counter. Emits one registered sample_valid pulse per completed sample to the per-unit detectors. Adds selectable byte order, inter-byte timeout and framing-error detection.

Parameters:
DATA_WIDTH, 16, sample width; multiple of 8, range 8..32; BPS = DATA_WIDTH/8 bytes per sample
NUM_UNITS, 4, channel count, range 2..8; CH_W = $clog2(NUM_UNITS)
MSB_FIRST, 1, 1 = first byte is most significant; 0 = first byte is least significant
TIMEOUT_CYCLES, 64, enabled cycles allowed between bytes of one sample; 0 disables timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; 0 freezes acceptance and the timeout counter
byte_in  input  8  sample byte (uio_in)
byte_valid  input  1  level strobe; each 0->1 transition delivers one byte
sel_in  input  CH_W  channel select, manual mode only
auto_mode  input  1  1 = channel from internal round-robin counter
clr_err  input  1  clears frame_err
sample_out  output  DATA_WIDTH  assembled sample
sample_ch  output  CH_W  channel of sample_out
sample_valid  output  1  one-cycle pulse, new sample
frame_err  output  1  sticky error flag
busy  output  1  high while a partial sample is held

Behaviour:
- Reset (async, rst_n=0): all outputs 0; bv_q, byte count, timeout counter, round-robin counter and accumulator 0; state IDLE.
- Edge detect: bv_q <= byte_valid every cycle, including when ena=0. A byte is accepted at an edge where ena=1, byte_valid=1 and bv_q=0. A strobe held high delivers exactly one byte.
- States: IDLE (no partial sample) and COLLECT (1..BPS-1 bytes held). busy = (state==COLLECT).
- Byte placement: MSB_FIRST=1 shifts left, acc = {acc[DATA_WIDTH-9:0], byte_in}. MSB_FIRST=0 writes byte k to bits [8k+7:8k], k = 0..BPS-1.
- Channel: manual mode latches sel_in on the first byte. Auto mode uses rr_ch and ignores sel_in.
- Completion: on the edge accepting byte BPS, sample_out, sample_ch and sample_valid=1 register at that edge, so the outputs are visible the next cycle (latency 1). The state returns to IDLE. In auto mode rr_ch increments and wraps NUM_UNITS-1 -> 0. sample_valid drops the following cycle. sample_out and sample_ch hold until the next completion.
- DATA_WIDTH=8: every accepted byte completes a sample; COLLECT is never entered.
- Channel change (manual, COLLECT): if sel_in differs from the latched channel on an accepted byte, the partial sample is discarded and frame_err is set. That byte becomes byte 1 of a new sample on the new sel_in.
- Timeout: in COLLECT with ena=1, the counter increments each cycle and clears on each accepted byte. When it reaches TIMEOUT_CYCLES, the partial sample is discarded, frame_err is set and the state returns to IDLE. rr_ch does not advance.
- auto_mode change mid-sample: treated like a channel change (discard, set frame_err, restart).
- frame_err is sticky. clr_err clears it. If an error occurs in the same cycle as clr_err, set wins.
- Async reset mid-sample discards everything and produces no sample_valid.

Test Plan:
- Reset check: rst_n low 8 cycles -> all outputs 0, busy 0. Release with byte_valid=1 held -> no byte accepted until byte_valid returns to 0 and rises again.
- Manual, MSB_FIRST=1, DATA_WIDTH=16: sel_in=2, bytes 0x12 then 0x34 -> sample_out=0x1234, sample_ch=2, sample_valid high exactly 1 cycle after the second accepting edge.
- MSB_FIRST=0, DATA_WIDTH=24: bytes 0xAA,0xBB,0xCC -> sample_out=0xCCBBAA. byte_valid held high 5 cycles per byte -> still exactly one sample.
- Auto mode, NUM_UNITS=4: 5 samples -> sample_ch sequence 0,1,2,3,0. A timeout inserted after sample 2's first byte -> frame_err=1, rr_ch stays 2, the next completed sample has ch 2.
- Manual channel change: byte 0x11 on sel 0, then 0x22 and 0x33 on sel 1 -> frame_err=1, sample_out=0x2233, ch 1, no ch-0 sample. clr_err together with a new error -> frame_err stays 1.
- Timeout: TIMEOUT_CYCLES=64, gap 63 cycles -> sample completes. Gap 64 -> discard, busy drops. ena=0 for 100 cycles mid-sample -> no timeout, sample completes after ena returns.

Source files
------------

// File: rtl/sample_stream_assembler_if.sv
// Byte-stream input / sample output bundle for sample_stream_assembler.
//
// Producer side (master) drives:
//   ena         block enable; 0 freezes acceptance and the timeout counter
//   byte_in     sample byte
//   byte_valid  level strobe; each 0->1 transition delivers one byte
//   sel_in      channel select, used in manual mode only
//   auto_mode   1 = channel taken from the internal round-robin counter
//   clr_err     clears the sticky frame_err flag
// Assembler side (slave) drives:
//   sample_out    assembled sample
//   sample_ch     channel of sample_out
//   sample_valid  one-cycle pulse per completed sample
//   frame_err     sticky framing / timeout error flag
//   busy          high while a partial sample is held
interface sample_stream_assembler_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_UNITS  = 4
);
  localparam int unsigned CH_W = $clog2(NUM_UNITS);

  logic                  ena;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic [CH_W-1:0]       sel_in;
  logic                  auto_mode;
  logic                  clr_err;

  logic [DATA_WIDTH-1:0] sample_out;
  logic [CH_W-1:0]       sample_ch;
  logic                  sample_valid;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output ena, byte_in, byte_valid, sel_in, auto_mode, clr_err,
    input  sample_out, sample_ch, sample_valid, frame_err, busy
  );

  modport slave (
    input  ena, byte_in, byte_valid, sel_in, auto_mode, clr_err,
    output sample_out, sample_ch, sample_valid, frame_err, busy
  );
endinterface

// File: rtl/sample_stream_assembler.sv
// Sample stream assembler: front end of the spike-detector top layer.
//
// Collects DATA_WIDTH/8 bytes from an 8-bit stream strobed by a level
// byte_valid pin into one sample, tags it with a channel (from sel_in or an
// internal round-robin counter) and emits a registered one-cycle sample_valid.
// A channel or mode change mid-sample, or an inter-byte timeout, discards the
// partial sample and raises the sticky frame_err flag.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      slave side of sample_stream_assembler_if (byte stream in,
//            sample / channel / valid / frame_err / busy out)
module sample_stream_assembler #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  sample_stream_assembler_if.slave bus
);

  localparam int unsigned BPS   = DATA_WIDTH / 8;
  localparam int unsigned CH_W  = $clog2(NUM_UNITS);
  localparam int unsigned CNT_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BPS - 1);
  localparam logic [CH_W-1:0]  ChLast  = CH_W'(NUM_UNITS - 1);
  localparam logic [TMO_W-1:0] TmoLast =
      (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } state_e;

  // State and datapath registers
  state_e                r_state;
  logic                  r_bv;
  logic                  r_armed;
  logic [CNT_W-1:0]      r_cnt;
  logic [TMO_W-1:0]      r_tmo;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CH_W-1:0]       r_ch;
  logic                  r_auto;
  logic [CH_W-1:0]       r_rr_ch;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [CH_W-1:0]       r_sample_ch;
  logic                  r_sample_valid;
  logic                  r_frame_err;

  // Next-state values
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [TMO_W-1:0]      w_tmo_nxt;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic [CH_W-1:0]       w_ch_nxt;
  logic                  w_auto_nxt;
  logic [CH_W-1:0]       w_rr_ch_nxt;
  logic [DATA_WIDTH-1:0] w_sample_nxt;
  logic [CH_W-1:0]       w_sample_ch_nxt;
  logic                  w_sample_valid_nxt;
  logic                  w_frame_err_nxt;

  // Decode helpers
  logic                  w_accept;
  logic                  w_mismatch;
  logic                  w_first;
  logic                  w_tmo_hit;
  logic                  w_set_err;
  logic [CH_W-1:0]       w_ch_now;
  logic [CNT_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_acc_base;
  logic [DATA_WIDTH-1:0] w_acc_msb;
  logic [DATA_WIDTH-1:0] w_acc_lsb;
  logic [DATA_WIDTH-1:0] w_acc_placed;

  // Byte acceptance. r_armed only matters right after reset: a strobe that is
  // already high when reset releases must go low and rise again before it
  // counts as a byte.
  assign w_accept = bus.ena & bus.byte_valid & ~r_bv & r_armed;

  assign w_ch_now = bus.auto_mode ? r_rr_ch : bus.sel_in;

  // A mode flip, or a manual channel change, while a partial sample is held
  // restarts assembly with the current byte as byte 1.
  assign w_mismatch = (r_state == StCollect) &&
                      ((bus.auto_mode != r_auto) ||
                       (!bus.auto_mode && (bus.sel_in != r_ch)));

  assign w_first = (r_state == StIdle) || w_mismatch;
  assign w_idx   = w_first ? '0 : r_cnt;

  // Fires on the enabled idle cycle that would bring the gap to TIMEOUT_CYCLES;
  // an accepted byte on that same cycle still counts as in time.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_state == StCollect) && bus.ena &&
                     !w_accept && (r_tmo == TmoLast);

  // Byte placement
  assign w_acc_base = w_first ? '0 : r_acc;
  assign w_acc_msb  = (w_acc_base << 8) | DATA_WIDTH'(bus.byte_in);

  always_comb begin
    w_acc_lsb = w_acc_base;
    for (int unsigned k = 0; k < BPS; k++) begin
      if (w_idx == CNT_W'(k)) begin
        w_acc_lsb[8*k +: 8] = bus.byte_in;
      end
    end
  end

  assign w_acc_placed = (MSB_FIRST != 0) ? w_acc_msb : w_acc_lsb;

  // Next-state / output logic
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_tmo_nxt          = r_tmo;
    w_acc_nxt          = r_acc;
    w_ch_nxt           = r_ch;
    w_auto_nxt         = r_auto;
    w_rr_ch_nxt        = r_rr_ch;
    w_sample_nxt       = r_sample;
    w_sample_ch_nxt    = r_sample_ch;
    w_sample_valid_nxt = 1'b0;
    w_set_err          = 1'b0;

    if (w_accept) begin
      w_set_err = w_mismatch;
      w_tmo_nxt = '0;
      if (w_first) begin
        w_ch_nxt   = w_ch_now;
        w_auto_nxt = bus.auto_mode;
      end
      if (w_idx == LastIdx) begin
        w_sample_nxt       = w_acc_placed;
        w_sample_ch_nxt    = w_first ? w_ch_now : r_ch;
        w_sample_valid_nxt = 1'b1;
        w_state_nxt        = StIdle;
        w_cnt_nxt          = '0;
        w_acc_nxt          = '0;
        if (bus.auto_mode) begin
          w_rr_ch_nxt = (r_rr_ch == ChLast) ? '0 : r_rr_ch + 1'b1;
        end
      end else begin
        w_state_nxt = StCollect;
        w_cnt_nxt   = w_idx + 1'b1;
        w_acc_nxt   = w_acc_placed;
      end
    end else if (w_tmo_hit) begin
      w_set_err   = 1'b1;
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
      w_tmo_nxt   = '0;
    end else if ((TIMEOUT_CYCLES != 0) && (r_state == StCollect) && bus.ena) begin
      w_tmo_nxt = r_tmo + 1'b1;
    end

    // A new error in the same cycle as clr_err leaves the flag set.
    w_frame_err_nxt = w_set_err | (r_frame_err & ~bus.clr_err);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_bv           <= 1'b0;
      r_armed        <= 1'b0;
      r_cnt          <= '0;
      r_tmo          <= '0;
      r_acc          <= '0;
      r_ch           <= '0;
      r_auto         <= 1'b0;
      r_rr_ch        <= '0;
      r_sample       <= '0;
      r_sample_ch    <= '0;
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      // Edge detector tracks the strobe even while disabled, so a strobe that
      // rises during ena=0 is not delivered later.
      r_bv           <= bus.byte_valid;
      r_armed        <= r_armed | ~bus.byte_valid;
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_tmo          <= w_tmo_nxt;
      r_acc          <= w_acc_nxt;
      r_ch           <= w_ch_nxt;
      r_auto         <= w_auto_nxt;
      r_rr_ch        <= w_rr_ch_nxt;
      r_sample       <= w_sample_nxt;
      r_sample_ch    <= w_sample_ch_nxt;
      r_sample_valid <= w_sample_valid_nxt;
      r_frame_err    <= w_frame_err_nxt;
    end
  end

  assign bus.sample_out   = r_sample;
  assign bus.sample_ch    = r_sample_ch;
  assign bus.sample_valid = r_sample_valid;
  assign bus.frame_err    = r_frame_err;
  assign bus.busy         = (r_state == StCollect);

endmodule
